// File: rtl/sync_fifo_pkg.sv
// Shared sizing constants and helpers for sync_fifo and its neighbours (signal_gen benches).
package sync_fifo_pkg;

  localparam int unsigned FIFO_DATA_WIDTH = 8;
  localparam int unsigned FIFO_ADDR_WIDTH = 3;

  // DEPTH derivation from the address width.
  function automatic int unsigned fifo_depth(input int unsigned addr_width);
    return 32'd1 << addr_width;
  endfunction

endpackage

// File: rtl/sync_fifo_if.sv
// Handshake/status bundle for sync_fifo. master = producer/consumer side, slave = FIFO.
interface sync_fifo_if
  import sync_fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = FIFO_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = FIFO_ADDR_WIDTH
);

  logic                  wr_en;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  rd_en;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  rd_valid;
  logic                  full;
  logic                  empty;
  logic [ADDR_WIDTH:0]   count;
  logic                  ovf_err;
  logic                  udf_err;

  modport master (
    output wr_en, wr_data, rd_en,
    input  rd_data, rd_valid, full, empty, count, ovf_err, udf_err
  );

  modport slave (
    input  wr_en, wr_data, rd_en,
    output rd_data, rd_valid, full, empty, count, ovf_err, udf_err
  );

endinterface

// File: rtl/sync_fifo_mem.sv
// DEPTH x DATA_WIDTH storage: one synchronous write port, one synchronous read port
// whose output register is the FIFO read data. Array contents are not reset.
module fifo_mem
  import sync_fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = FIFO_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = FIFO_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en_i,
  input  logic [ADDR_WIDTH-1:0] wr_addr_i,
  input  logic [DATA_WIDTH-1:0] wr_data_i,
  input  logic                  rd_en_i,
  input  logic [ADDR_WIDTH-1:0] rd_addr_i,
  output logic [DATA_WIDTH-1:0] rd_data_o
);

  localparam int unsigned DEPTH = fifo_depth(ADDR_WIDTH);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] rd_data_q;

  // Write port.
  always_ff @(posedge clk) begin
    if (wr_en_i) mem_q[wr_addr_i] <= wr_data_i;
  end

  // Registered read port; holds last word when no read is accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       rd_data_q <= '0;
    else if (rd_en_i) rd_data_q <= mem_q[rd_addr_i];
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered read data and occupancy count.
// Optional sticky overflow/underflow flags: define FIFO_ERR_FLAG_EN.
module sync_fifo
  import sync_fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = FIFO_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = FIFO_ADDR_WIDTH
) (
  input  logic        clk,
  input  logic        rst_n,
  sync_fifo_if.slave  bus
);

  localparam int unsigned PTR_W = ADDR_WIDTH + 1;

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic             rd_valid_q, rd_valid_d;
  logic             full_c, empty_c;
  logic [PTR_W-1:0] count_c;
  logic             wr_acc_c, rd_acc_c;

  // Status straight from the registered pointers; MSB is the wrap bit.
  always_comb begin
    empty_c  = (wr_ptr_q == rd_ptr_q);
    full_c   = (wr_ptr_q[PTR_W-1] != rd_ptr_q[PTR_W-1]) &&
               (wr_ptr_q[ADDR_WIDTH-1:0] == rd_ptr_q[ADDR_WIDTH-1:0]);
    count_c  = wr_ptr_q - rd_ptr_q;
    wr_acc_c = bus.wr_en && !full_c;
    rd_acc_c = bus.rd_en && !empty_c;
  end

  // Pointer advance and read-valid next state.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    rd_valid_d = 1'b0;
    if (wr_acc_c) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (rd_acc_c) begin
      rd_ptr_d   = rd_ptr_q + PTR_W'(1);
      rd_valid_d = 1'b1;
    end
  end

  // Pointer and read-valid registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_mem (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en_i   (wr_acc_c),
    .wr_addr_i (wr_ptr_q[ADDR_WIDTH-1:0]),
    .wr_data_i (bus.wr_data),
    .rd_en_i   (rd_acc_c),
    .rd_addr_i (rd_ptr_q[ADDR_WIDTH-1:0]),
    .rd_data_o (bus.rd_data)
  );

`ifdef FIFO_ERR_FLAG_EN
  logic ovf_err_q, ovf_err_d;
  logic udf_err_q, udf_err_d;

  // Sticky error next state: any request against the wrong boundary.
  always_comb begin
    ovf_err_d = ovf_err_q | (bus.wr_en & full_c);
    udf_err_d = udf_err_q | (bus.rd_en & empty_c);
  end

  // Sticky error registers, cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_err_q <= 1'b0;
      udf_err_q <= 1'b0;
    end else begin
      ovf_err_q <= ovf_err_d;
      udf_err_q <= udf_err_d;
    end
  end

  assign bus.ovf_err = ovf_err_q;
  assign bus.udf_err = udf_err_q;
`else
  assign bus.ovf_err = 1'b0;
  assign bus.udf_err = 1'b0;
`endif

  assign bus.rd_valid = rd_valid_q;
  assign bus.full     = full_c;
  assign bus.empty    = empty_c;
  assign bus.count    = count_c;

endmodule

// File: tb/tb_sync_fifo.sv
// Self-checking bench for sync_fifo: reference queue model plus read-data scoreboard.
module tb_sync_fifo;

  localparam int unsigned DW    = 8;
  localparam int unsigned AW    = 3;
  localparam int unsigned DEPTH = 8;

  logic clk;
  logic rst_n;

  sync_fifo_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  sync_fifo #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int unsigned n_checks;
  int unsigned n_errors;

  logic [DW-1:0] model_q [$];
  logic [DW-1:0] exp_q   [$];
  logic          model_ovf;
  logic          model_udf;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_status(input string tag);
    check({tag, ".count"}, 32'(bus.count), 32'(model_q.size()));
    check({tag, ".full"},  32'(bus.full),  32'(model_q.size() == DEPTH));
    check({tag, ".empty"}, 32'(bus.empty), 32'(model_q.size() == 0));
`ifdef FIFO_ERR_FLAG_EN
    check({tag, ".ovf"}, 32'(bus.ovf_err), 32'(model_ovf));
    check({tag, ".udf"}, 32'(bus.udf_err), 32'(model_udf));
`else
    check({tag, ".ovf"}, 32'(bus.ovf_err), 32'd0);
    check({tag, ".udf"}, 32'(bus.udf_err), 32'd0);
`endif
  endtask

  // One clock with the given requests; inputs change #1 after the rising edge.
  task automatic cycle(input string tag, input logic wr, input logic [DW-1:0] data, input logic rd);
    logic exp_rd;
    logic exp_wr;
    logic [DW-1:0] want;
    exp_rd = rd && (model_q.size() != 0);
    exp_wr = wr && (model_q.size() != DEPTH);
    if (wr && !exp_wr) model_ovf = 1'b1;
    if (rd && !exp_rd) model_udf = 1'b1;
    if (exp_rd) exp_q.push_back(model_q.pop_front());
    if (exp_wr) model_q.push_back(data);
    bus.wr_en   = wr;
    bus.wr_data = data;
    bus.rd_en   = rd;
    @(posedge clk);
    #1;
    bus.wr_en = 1'b0;
    bus.rd_en = 1'b0;
    check({tag, ".rd_valid"}, 32'(bus.rd_valid), 32'(exp_rd));
    if (bus.rd_valid) begin
      if (exp_q.size() == 0) begin
        check({tag, ".unexpected_pop"}, 32'(bus.rd_data), 32'hFFFF_FFFF);
      end else begin
        want = exp_q.pop_front();
        check({tag, ".rd_data"}, 32'(bus.rd_data), 32'(want));
      end
    end
    check_status(tag);
  endtask

  task automatic model_reset();
    model_q.delete();
    exp_q.delete();
    model_ovf = 1'b0;
    model_udf = 1'b0;
  endtask

  initial begin
    n_checks    = 0;
    n_errors    = 0;
    bus.wr_en   = 1'b0;
    bus.wr_data = '0;
    bus.rd_en   = 1'b0;
    model_reset();

    // Reset held for two cycles.
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset.rd_valid", 32'(bus.rd_valid), 32'd0);
    check("reset.rd_data",  32'(bus.rd_data),  32'd0);
    check_status("reset");
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Fill 0x10..0x17, then one rejected write.
    for (int i = 0; i < 8; i++) cycle("fill", 1'b1, DW'(8'h10 + i), 1'b0);
    cycle("fill_ovf", 1'b1, 8'hFF, 1'b0);

    // Drain in order, then one rejected read.
    for (int i = 0; i < 8; i++) cycle("drain", 1'b0, '0, 1'b1);
    cycle("drain_udf", 1'b0, '0, 1'b1);

    // Alternating write/read across pointer wrap.
    for (int i = 0; i < 20; i++) begin
      cycle("wrap_wr", 1'b1, DW'(i), 1'b0);
      cycle("wrap_rd", 1'b0, '0, 1'b1);
    end

    // Simultaneous request at full: read only.
    for (int i = 0; i < 8; i++) cycle("refill", 1'b1, DW'(8'h40 + i), 1'b0);
    cycle("full_wr_rd", 1'b1, 8'hAA, 1'b1);
    check("full_wr_rd.count7", 32'(bus.count), 32'd7);
    for (int i = 0; i < 7; i++) cycle("redrain", 1'b0, '0, 1'b1);

    // Simultaneous request at empty: write only.
    cycle("empty_wr_rd", 1'b1, 8'h5C, 1'b1);
    check("empty_wr_rd.count1", 32'(bus.count), 32'd1);
    cycle("empty_wr_rd_pop", 1'b0, '0, 1'b1);

    // Mixed random traffic.
    for (int i = 0; i < 60; i++)
      cycle("random", 1'($urandom_range(0, 1)), DW'($urandom), 1'($urandom_range(0, 1)));

    // Drain, then build count 5 with a pop on the last cycle so rd_valid is high.
    while (model_q.size() != 0) cycle("pre_rst", 1'b0, '0, 1'b1);
    for (int i = 0; i < 6; i++) cycle("pre_rst_fill", 1'b1, DW'(8'hC0 + i), 1'b0);
    cycle("pre_rst_pop", 1'b0, '0, 1'b1);
    check("pre_rst.count5", 32'(bus.count), 32'd5);

    // Async reset mid-stream, away from the clock edge.
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check("async_rst.rd_valid", 32'(bus.rd_valid), 32'd0);
    check("async_rst.rd_data",  32'(bus.rd_data),  32'd0);
    check_status("async_rst");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    cycle("post_rst_rd", 1'b0, '0, 1'b1);
    cycle("post_rst_wr", 1'b1, 8'h77, 1'b0);
    cycle("post_rst_rd2", 1'b0, '0, 1'b1);

    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
